// File: rtl/rv32_if_pkg.sv
// Shared opcode constants, fetch FSM encoding and immediate helpers for the
// RV32IMA instruction-fetch stage.
package rv32_if_pkg;

    localparam logic [6:0]  OPC_JAL       = 7'b1101111;
    localparam logic [6:0]  OPC_JALR      = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH    = 7'b1100011;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/imm_target_gen.sv
// Combinational JAL / branch target generator: pc + sign-extended J- or
// B-immediate, 32-bit wrap-around.
module imm_target_gen
    import rv32_if_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] target
);

    logic [31:0] imm;

    always_comb begin
        imm = (instr[6:0] == OPC_JAL) ? imm_j(instr) : imm_b(instr);
        target = pc + imm;
    end

endmodule

// File: rtl/if_pc_stage.sv
// IF/PC-generation stage: PC register, next-PC select, IF/ID register and
// flush generation. Optional misaligned-target pulse: PC_MISALIGN_CHK_EN.
module if_pc_stage
    import rv32_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    input  logic        stall_i,
    input  logic        branch_condition_i,
    input  logic [31:0] alu_result_ex_i,
    output logic [31:0] pc_next_if_o,
    output logic [31:0] pc_reg_id_o,
    output logic [31:0] instruction_id_o,
    output logic [31:0] branch_adder_id_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        misalign_o
);

    logic [31:0]  pc_reg_if;
    logic [31:0]  pc_reg_id;
    logic [31:0]  instruction_id;
    logic [31:0]  branch_adder_id;
    logic [31:0]  pc_plus4;
    logic [31:0]  jalr_target;
    logic [6:0]   opcode_id;
    logic         jalr_ex;
    logic         jalr_ex_nxt;
    logic         is_jal;
    logic         taken;
    logic         redirect_id;
    logic         flush;
    logic         pc_load;
    logic         ifid_fetch;
    logic         ifid_bubble;
    fetch_state_t state;
    fetch_state_t state_nxt;

    imm_target_gen u_imm_target_gen (
        .pc     (pc_reg_id),
        .instr  (instruction_id),
        .target (branch_adder_id)
    );

    assign opcode_id = instruction_id[6:0];

    always_comb begin
        is_jal      = (opcode_id == OPC_JAL);
        taken       = (opcode_id == OPC_BRANCH) && (instruction_id[12] ^ branch_condition_i);
        redirect_id = (is_jal || taken) && !jalr_ex;
        pc_plus4    = pc_reg_if + 32'd4;
        jalr_target = alu_result_ex_i & 32'hFFFF_FFFE;

        if (jalr_ex) begin
            pc_next_if_o = jalr_target;
        end else if (is_jal || taken) begin
            pc_next_if_o = branch_adder_id;
        end else begin
            pc_next_if_o = pc_plus4;
        end

        // JALR in EX is older than any stall, so it redirects regardless.
        flush       = jalr_ex || (redirect_id && !stall_i);
        jalr_ex_nxt = (opcode_id == OPC_JALR) && !stall_i && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = imem_ready_i ? RUN : WAIT;
            WAIT:    state_nxt = (imem_ready_i && !flush) ? RUN : WAIT;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        pc_load     = 1'b0;
        ifid_fetch  = 1'b0;
        ifid_bubble = 1'b0;
        case (state)
            BOOT: begin
                ifid_bubble = 1'b1;
            end
            RUN, WAIT: begin
                if (flush) begin
                    pc_load     = 1'b1;
                    ifid_bubble = 1'b1;
                end else if (!stall_i) begin
                    if (imem_ready_i) begin
                        pc_load    = 1'b1;
                        ifid_fetch = 1'b1;
                    end else begin
                        ifid_bubble = 1'b1;
                    end
                end
            end
            default: begin
                ifid_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg_if      <= RESET_PC;
            pc_reg_id      <= '0;
            instruction_id <= NOP_INSTR;
            jalr_ex        <= 1'b0;
        end else begin
            if (pc_load) begin
                pc_reg_if <= pc_next_if_o;
            end
            if (ifid_fetch) begin
                pc_reg_id      <= pc_reg_if;
                instruction_id <= imem_rdata_i;
            end else if (ifid_bubble) begin
                pc_reg_id      <= pc_reg_if;
                instruction_id <= NOP_INSTR;
            end
            jalr_ex <= jalr_ex_nxt;
        end
    end

`ifdef PC_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= flush && pc_next_if_o[1];
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign imem_addr_o       = pc_reg_if;
    assign pc_reg_id_o       = pc_reg_id;
    assign instruction_id_o  = instruction_id;
    assign branch_adder_id_o = branch_adder_id;
    assign if_id_flush_o     = flush;
    assign id_ex_flush_o     = jalr_ex;

endmodule

// File: tb/tb_if_pc_stage.sv
// Directed bench for if_pc_stage: a vector table for sequential fetch, JAL and
// branches, then hand sequences for JALR, stall, wait-state and reset corners.
module tb_if_pc_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_ready_i;
    logic        stall_i;
    logic        branch_condition_i;
    logic [31:0] alu_result_ex_i;
    logic [31:0] pc_next_if_o;
    logic [31:0] pc_reg_id_o;
    logic [31:0] instruction_id_o;
    logic [31:0] branch_adder_id_o;
    logic        if_id_flush_o;
    logic        id_ex_flush_o;
    logic        misalign_o;

    logic [31:0] mem [4096];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        cond;
        logic [31:0] alu;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
        logic [31:0] exp_pc_id;
        logic [31:0] exp_instr;
        logic [31:0] exp_adder;
        logic        chk_adder;
        logic        exp_fif;
        logic        exp_fid;
    } vec_t;

    vec_t tbl [12];

    if_pc_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .imem_addr_o        (imem_addr_o),
        .imem_rdata_i       (imem_rdata_i),
        .imem_ready_i       (imem_ready_i),
        .stall_i            (stall_i),
        .branch_condition_i (branch_condition_i),
        .alu_result_ex_i    (alu_result_ex_i),
        .pc_next_if_o       (pc_next_if_o),
        .pc_reg_id_o        (pc_reg_id_o),
        .instruction_id_o   (instruction_id_o),
        .branch_adder_id_o  (branch_adder_id_o),
        .if_id_flush_o      (if_id_flush_o),
        .id_ex_flush_o      (id_ex_flush_o),
        .misalign_o         (misalign_o)
    );

    always #5 clk = ~clk;

    assign imem_rdata_i = mem[imem_addr_o[13:2]];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = NOP;
    endtask

    task automatic drive(input logic st, input logic rd, input logic cond, input logic [31:0] alu);
        stall_i            = st;
        imem_ready_i       = rd;
        branch_condition_i = cond;
        alu_result_ex_i    = alu;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and step through the BOOT edge; leaves pc_if=0, IF/ID=NOP.
    task automatic boot();
        reset = 1'b1;
        stall_i = 1'b0;
        imem_ready_i = 1'b1;
        branch_condition_i = 1'b0;
        alu_result_ex_i = '0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset              = 1'b1;
        stall_i            = 1'b0;
        imem_ready_i       = 1'b1;
        branch_condition_i = 1'b0;
        alu_result_ex_i    = 32'h0000_2001;

        // Program A: sequential fetch, JAL +0x38, JAL +0x100, BEQ +0x20, BNE +0x40
        clear_mem();
        mem[32'h000 >> 2] = 32'h0010_0093;
        mem[32'h004 >> 2] = 32'h0020_0113;
        mem[32'h008 >> 2] = 32'h0380_006F;
        mem[32'h040 >> 2] = 32'h1000_006F;
        mem[32'h140 >> 2] = 32'h0200_0063;
        mem[32'h160 >> 2] = 32'h0400_1063;
        mem[32'h164 >> 2] = 32'h0030_0193;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h2001, 32'h000, 32'h004, 32'h000, NOP,          32'h000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h2001, 32'h000, 32'h004, 32'h000, NOP,          32'h000, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h2001, 32'h004, 32'h008, 32'h000, 32'h00100093, 32'h000, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h2001, 32'h008, 32'h00C, 32'h004, 32'h00200113, 32'h000, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h2001, 32'h00C, 32'h040, 32'h008, 32'h0380006F, 32'h040, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h2001, 32'h040, 32'h044, 32'h00C, NOP,          32'h00C, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h2001, 32'h044, 32'h140, 32'h040, 32'h1000006F, 32'h140, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h2001, 32'h140, 32'h144, 32'h044, NOP,          32'h044, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h2001, 32'h144, 32'h160, 32'h140, 32'h02000063, 32'h160, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h2001, 32'h160, 32'h164, 32'h144, NOP,          32'h144, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h2001, 32'h164, 32'h168, 32'h160, 32'h04001063, 32'h1A0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h2001, 32'h168, 32'h16C, 32'h164, 32'h00300193, 32'h000, 1'b0, 1'b0, 1'b0};

        @(negedge clk);
        chk32("reset_pc_if",   imem_addr_o, 32'h0);
        chk32("reset_pc_id",   pc_reg_id_o, 32'h0);
        chk32("reset_instr",   instruction_id_o, NOP);
        chk1 ("reset_id_ex",   id_ex_flush_o, 1'b0);
        chk1 ("reset_misalign", misalign_o, 1'b0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].stall, tbl[i].ready, tbl[i].cond, tbl[i].alu);
            chk32($sformatf("A%0d_addr", i),  imem_addr_o,      tbl[i].exp_addr);
            chk32($sformatf("A%0d_next", i),  pc_next_if_o,     tbl[i].exp_next);
            chk32($sformatf("A%0d_pc_id", i), pc_reg_id_o,      tbl[i].exp_pc_id);
            chk32($sformatf("A%0d_instr", i), instruction_id_o, tbl[i].exp_instr);
            if (tbl[i].chk_adder)
                chk32($sformatf("A%0d_adder", i), branch_adder_id_o, tbl[i].exp_adder);
            chk1($sformatf("A%0d_if_flush", i), if_id_flush_o, tbl[i].exp_fif);
            chk1($sformatf("A%0d_id_flush", i), id_ex_flush_o, tbl[i].exp_fid);
            tick();
        end

        // Program B: JALR then JAL; JALR in EX wins even while stalled
        clear_mem();
        mem[32'h000 >> 2]  = 32'h0000_8067;
        mem[32'h004 >> 2]  = 32'h1000_006F;
        mem[32'h2000 >> 2] = 32'h0010_0093;
        boot();
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h2001);
        chk32("B1_instr", instruction_id_o, 32'h0000_8067);
        chk32("B1_next",  pc_next_if_o, 32'h008);
        chk1 ("B1_if_flush", if_id_flush_o, 1'b0);
        chk1 ("B1_id_flush", id_ex_flush_o, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h2001);
        chk32("B2_instr", instruction_id_o, 32'h1000_006F);
        chk32("B2_pc_id", pc_reg_id_o, 32'h004);
        chk32("B2_next",  pc_next_if_o, 32'h2000);
        chk1 ("B2_if_flush", if_id_flush_o, 1'b1);
        chk1 ("B2_id_flush", id_ex_flush_o, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk32("B3_addr",  imem_addr_o, 32'h2000);
        chk32("B3_instr", instruction_id_o, NOP);
        chk32("B3_pc_id", pc_reg_id_o, 32'h008);
        chk1 ("B3_if_flush", if_id_flush_o, 1'b0);
        chk1 ("B3_id_flush", id_ex_flush_o, 1'b0);
        chk1 ("B3_misalign", misalign_o, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk32("B4_instr", instruction_id_o, 32'h0010_0093);
        chk32("B4_pc_id", pc_reg_id_o, 32'h2000);
        tick();

        // Program C: JAL -8 at 0x4 held by a 3-cycle stall, target wraps to 0xFFFFFFFC
        clear_mem();
        mem[32'h004 >> 2] = 32'hFF9F_F06F;
        mem[4095]         = 32'h0050_0293;
        boot();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            chk32($sformatf("C_stall%0d_addr", i),  imem_addr_o, 32'h008);
            chk32($sformatf("C_stall%0d_instr", i), instruction_id_o, 32'hFF9F_F06F);
            chk32($sformatf("C_stall%0d_pc_id", i), pc_reg_id_o, 32'h004);
            chk32($sformatf("C_stall%0d_adder", i), branch_adder_id_o, 32'hFFFF_FFFC);
            chk1 ($sformatf("C_stall%0d_if_flush", i), if_id_flush_o, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk32("C5_next", pc_next_if_o, 32'hFFFF_FFFC);
        chk1 ("C5_if_flush", if_id_flush_o, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk32("C6_addr",  imem_addr_o, 32'hFFFF_FFFC);
        chk32("C6_next",  pc_next_if_o, 32'h0);
        chk32("C6_pc_id", pc_reg_id_o, 32'h008);
        chk32("C6_instr", instruction_id_o, NOP);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk32("C7_addr",  imem_addr_o, 32'h0);
        chk32("C7_instr", instruction_id_o, 32'h0050_0293);
        chk32("C7_pc_id", pc_reg_id_o, 32'hFFFF_FFFC);
        tick();

        // Program D: taken BEQ while memory is not ready for 2 cycles
        clear_mem();
        mem[32'h004 >> 2] = 32'h0200_0063;
        mem[32'h008 >> 2] = 32'h0070_0393;
        mem[32'h024 >> 2] = 32'h0090_0493;
        boot();
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        chk32("D2_instr", instruction_id_o, 32'h0200_0063);
        chk32("D2_next",  pc_next_if_o, 32'h024);
        chk1 ("D2_if_flush", if_id_flush_o, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk32("D3_addr",  imem_addr_o, 32'h024);
        chk32("D3_instr", instruction_id_o, NOP);
        chk32("D3_pc_id", pc_reg_id_o, 32'h008);
        chk1 ("D3_if_flush", if_id_flush_o, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk32("D4_addr",  imem_addr_o, 32'h024);
        chk32("D4_instr", instruction_id_o, NOP);
        chk32("D4_pc_id", pc_reg_id_o, 32'h024);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk32("D5_addr",  imem_addr_o, 32'h028);
        chk32("D5_instr", instruction_id_o, 32'h0090_0493);
        chk32("D5_pc_id", pc_reg_id_o, 32'h024);

        // Asynchronous reset mid-operation, sampled before any clock edge
        reset = 1'b1;
        #1;
        chk32("R_addr",  imem_addr_o, 32'h0);
        chk32("R_pc_id", pc_reg_id_o, 32'h0);
        chk32("R_instr", instruction_id_o, NOP);
        chk1 ("R_id_flush", id_ex_flush_o, 1'b0);
        tick();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_pc_stage.md
Name: if_pc_stage

Overview:
- Instruction-fetch / PC-generation stage of the RV32IMA pipeline.
- Owns the PC register, the next-PC select, and the IF/ID pipeline register.
- Computes JAL/branch targets in ID, tracks JALR into EX, and issues the IF/ID and ID/EX flushes.
- Its outputs are the signals the branch checker observes: pc_next_if, pc_reg_id, instruction_id, branch_adder_id, id_ex_flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded by reset
NOP_INSTR, 32'h0000_0013, bubble injected into IF/ID (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-high reset
imem_addr_o  out  32  fetch address (equals pc_reg_if)
imem_rdata_i  in  32  instruction at imem_addr_o, valid when imem_ready_i=1
imem_ready_i  in  1  memory returned imem_rdata_i this cycle
stall_i  in  1  hazard-unit stall of PC and IF/ID
branch_condition_i  in  1  ID comparator result (eq / lt per funct3)
alu_result_ex_i  in  32  JALR target computed in EX
pc_next_if_o  out  32  selected next PC (combinational)
pc_reg_id_o  out  32  PC of instruction in ID
instruction_id_o  out  32  instruction in ID
branch_adder_id_o  out  32  pc_reg_id + J- or B-immediate
if_id_flush_o  out  1  IF/ID loaded with NOP this edge
id_ex_flush_o  out  1  downstream must bubble ID/EX
misalign_o  out  1  see Optional Feature

Behaviour:
- Reset values (async):
  - pc_reg_if = RESET_PC; pc_reg_id = 0; instruction_id = NOP_INSTR.
  - jalr_ex flag = 0; fetch FSM = BOOT; misalign_o = 0.
- branch_adder_id_o:
  - opcode 1101111 (JAL): pc_reg_id + sign-extended J-imm.
  - Otherwise: pc_reg_id + sign-extended B-imm.
  - 32-bit wrap-around, no overflow flag.
- taken = (opcode==1100011) && (instruction_id[12] ^ branch_condition_i).
- jalr_ex flag:
  - Set on an edge where instruction_id opcode is 1100111 AND stall_i=0 AND no flush occurs.
  - Cleared on every other edge.
- pc_next_if_o priority (highest first):
  1. jalr_ex: {alu_result_ex_i[31:1],1'b0}; if_id_flush_o=1, id_ex_flush_o=1.
  2. ID JAL: branch_adder_id_o; if_id_flush_o=1.
  3. ID taken branch: branch_adder_id_o; if_id_flush_o=1.
  4. Otherwise: pc_reg_if+4, wrapping at 2^32.
- Redirects 2 and 3 are suppressed while jalr_ex=1; rule 1 wins.
- stall_i=1:
  - PC and IF/ID hold.
  - Exception: rule 1 still loads the PC and flushes IF/ID, because JALR in EX is older than the stall.
  - JAL/branch redirects wait until the stall drops.
- Fetch FSM:
  - BOOT: one cycle after reset release; IF/ID gets NOP; PC holds; then RUN.
  - RUN, imem_ready_i=1, no stall: IF/ID <= {pc_reg_if, imem_rdata_i}; PC <= pc_next_if_o.
  - RUN, imem_ready_i=0: PC holds; IF/ID <= NOP (unless stalled); go to WAIT.
  - WAIT: same as RUN, but the first imem_ready_i=1 returns to RUN.
  - Redirect in WAIT: PC <= target; the pending fetch is dropped; stay in WAIT.
- A flush forces IF/ID <= NOP_INSTR with pc_reg_id = pc_reg_if, regardless of imem_ready_i.
- Reset asserted mid-operation: all state returns to reset values immediately; the in-flight fetch is discarded.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined:
  - misalign_o is a registered one-cycle pulse when a taken redirect (rules 1–3) has target[1]=1.
  - The PC is still loaded with the target; the trap unit handles the exception.
- Undefined: misalign_o tied to 0 and the logic is not generated.

Decomposition:
- Package rv32_if_pkg:
  - Opcode constants OPC_JAL, OPC_JALR, OPC_BRANCH.
  - NOP_INSTR default.
  - fetch_state_t enum {BOOT, RUN, WAIT}.
- Sub-module imm_target_gen (combinational):
  - J/B immediate extraction plus adder producing branch_adder_id.
  - Reused by the decoder.

Test Plan:
- Reset release, imem_ready_i=1, sequential NOPs → cycle 1 BOOT bubble; imem_addr_o goes 0x0, 0x4, 0x8; instruction_id lags by one cycle.
- JAL with imm=+0x100 at pc_reg_id=0x40 → branch_adder_id_o=0x140, pc_next_if_o=0x140, if_id_flush_o=1, next instruction_id=NOP.
- BEQ (funct3=000) with branch_condition_i=1 → taken to target. BNE (funct3=001) with branch_condition_i=1 → not taken, pc+4.
- JALR in ID, then JAL in ID next cycle with alu_result_ex_i=0x2001 → pc_next_if_o=0x2000, both flushes=1, JAL ignored.
- stall_i=1 for 3 cycles with JAL in ID → PC/IF/ID held, no flush; redirect on the first unstalled cycle.
- imem_ready_i=0 for 2 cycles while a branch is taken → PC=target, stale data dropped, NOPs injected, fetch resumes at target.
